// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, odd-parity serialisation,
// device ACK check and bus release over open-collector ps2_clk/ps2_data.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int SETUP_CYCLES   = 20,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int PhaseMax = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int PhaseW   = $clog2(PhaseMax + 1);
    localparam int ToW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FiltW    = $clog2(FILTER_LEN + 1);
    localparam int BitW     = $clog2(10 + 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, SETUP, SEND, ACK, WAIT_IDLE, DONE, ERR
    } state_e;

    // Index 0 is ps2_clk, index 1 is ps2_data.
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       filt_q;
    logic [FiltW-1:0] fcnt_q [2];
    logic             clk_fall_q;

    state_e            state_q;
    logic [9:0]        frame_q;
    logic [PhaseW-1:0] phase_q;
    logic [BitW-1:0]   bit_q;
    logic [ToW-1:0]    to_q;
    logic              clk_oe_q;
    logic              data_oe_q;
    logic              busy_q;
    logic              ready_q;
    logic              done_q;
    logic              err_q;
    logic              timeout_hit;

    assign timeout_hit = (to_q == ToW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            filt_q     <= '1;
            clk_fall_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= {ps2_data_i, ps2_clk_i};
            sync2_q    <= sync1_q;
            clk_fall_q <= 1'b0;
            // A line only changes after FILTER_LEN consecutive disagreeing samples.
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FiltW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                    if (i == 0 && filt_q[i]) begin
                        clk_fall_q <= 1'b1;
                    end
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            phase_q   <= '0;
            bit_q     <= '0;
            to_q      <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid && ready_q) begin
                        frame_q  <= {1'b1, ~^tx_data, tx_data};
                        phase_q  <= '0;
                        clk_oe_q <= 1'b1;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                        state_q  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (phase_q == PhaseW'(INHIBIT_CYCLES - 1)) begin
                        phase_q   <= '0;
                        data_oe_q <= 1'b1;
                        state_q   <= SETUP;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                SETUP: begin
                    if (phase_q == PhaseW'(SETUP_CYCLES - 1)) begin
                        phase_q  <= '0;
                        bit_q    <= '0;
                        to_q     <= '0;
                        clk_oe_q <= 1'b0;
                        state_q  <= SEND;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                SEND: begin
                    to_q <= to_q + 1'b1;
                    if (timeout_hit) begin
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= ERR;
                    end else if (clk_fall_q) begin
                        // Stop bit is 1, so the tenth fall releases data.
                        data_oe_q <= ~frame_q[bit_q];
                        bit_q     <= bit_q + 1'b1;
                        if (bit_q == BitW'(9)) begin
                            state_q <= ACK;
                        end
                    end
                end
                ACK: begin
                    to_q <= to_q + 1'b1;
                    if (timeout_hit) begin
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= ERR;
                    end else if (clk_fall_q) begin
                        if (!filt_q[1]) begin
                            state_q <= WAIT_IDLE;
                        end else begin
                            data_oe_q <= 1'b0;
                            err_q     <= 1'b1;
                            state_q   <= ERR;
                        end
                    end
                end
                WAIT_IDLE: begin
                    to_q <= to_q + 1'b1;
                    if (timeout_hit) begin
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= ERR;
                    end else if (filt_q[0] && filt_q[1]) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE, ERR: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    ready_q   <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign tx_ready    = ready_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-collector bus with a behavioural
// PS/2 device that clocks the frame, records the sampled bits and optionally ACKs.
module tb_ps2_host_tx;

    localparam int INHIBIT = 200;
    localparam int SETUP   = 20;
    localparam int TIMEOUT = 4000;
    localparam int FLEN    = 8;
    localparam int HALF    = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
    logic       ps2_clk_i, ps2_data_i;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .SETUP_CYCLES  (SETUP),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FILTER_LEN    (FLEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    // Pulse counters; a pulse wider than one cycle counts more than once.
    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_err === 1'b1) err_cnt++;
    end

    // Reference frame as the device should see it after the start bit.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic device_xfer(input bit do_ack, input int glitch_at,
                               output logic start_bit, output logic [9:0] bits, output bit ok);
        int n;
        ok = 1'b1;
        bits = '0;
        start_bit = 1'b1;
        n = 0;
        while (!(ps2_data_oe === 1'b1 && ps2_clk_oe === 1'b0) && n < 3 * (INHIBIT + SETUP)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3 * (INHIBIT + SETUP)) begin
            ok = 1'b0;
            return;
        end
        start_bit = ps2_data_i;
        repeat (30) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            bits[k-1] = ps2_data_i;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k == glitch_at) begin
                dev_clk_low = 1'b1;
                repeat (5) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (30) @(negedge clk);
            end
        end
        dev_data_low = do_ack;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
        dev_data_low = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic run_transfer(input logic [7:0] b, input bit do_ack, input int glitch_at, input string tag);
        logic [9:0] want;
        logic [9:0] bits;
        logic       sb;
        bit         ok;
        int         n, m, d0, e0;
        want = model_frame(b);
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        total++;
        if ({busy, ps2_clk_oe, ps2_data_oe} !== 3'b110) begin
            bad++;
            $display("[TB] FAIL %s accept: busy/clk_oe/data_oe=%b want 110", tag, {busy, ps2_clk_oe, ps2_data_oe});
        end
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 2 * INHIBIT) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== INHIBIT) begin
            bad++;
            $display("[TB] FAIL %s inhibit: got %0d cycles want %0d", tag, n, INHIBIT);
        end
        m = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && m < 2 * SETUP) begin
            m++;
            @(negedge clk);
        end
        total++;
        if (m !== SETUP) begin
            bad++;
            $display("[TB] FAIL %s setup: got %0d cycles want %0d", tag, m, SETUP);
        end
        device_xfer(do_ack, glitch_at, sb, bits, ok);
        total++;
        if (!ok || sb !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s start: got %b (release seen %0d) want 0", tag, sb, ok);
        end
        total++;
        if (bits !== want) begin
            bad++;
            $display("[TB] FAIL %s frame: got %b want %b", tag, bits, want);
        end
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        total++;
        if ((done_cnt - d0) !== (do_ack ? 1 : 0) || (err_cnt - e0) !== (do_ack ? 0 : 1)) begin
            bad++;
            $display("[TB] FAIL %s result: done=%0d err=%0d want done=%0d err=%0d",
                     tag, done_cnt - d0, err_cnt - e0, do_ack ? 1 : 0, do_ack ? 0 : 1);
        end
        total++;
        if ({ps2_clk_oe, ps2_data_oe, busy, tx_ready} !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL %s release: clk_oe/data_oe/busy/ready=%b want 0001",
                     tag, {ps2_clk_oe, ps2_data_oe, busy, tx_ready});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({ps2_clk_oe, ps2_data_oe, busy, tx_ready, tx_done, tx_err} !== 6'b000100) begin
            bad++;
            $display("[TB] FAIL reset: oe/oe/busy/ready/done/err=%b want 000100",
                     {ps2_clk_oe, ps2_data_oe, busy, tx_ready, tx_done, tx_err});
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_f4();
        run_transfer(8'hF4, 1'b1, 0, "f4");
    endtask

    task automatic test_parity();
        run_transfer(8'h00, 1'b1, 0, "x00");
        run_transfer(8'hFF, 1'b1, 0, "xff");
    endtask

    task automatic test_no_ack();
        run_transfer(8'hF4, 1'b0, 0, "noack");
    endtask

    task automatic test_timeout();
        int n, e0, d0;
        e0 = err_cnt;
        d0 = done_cnt;
        @(negedge clk);
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 3 * (INHIBIT + SETUP)) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (tx_err !== 1'b1 && n < 2 * TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== TIMEOUT) begin
            bad++;
            $display("[TB] FAIL timeout: err after %0d cycles want %0d", n, TIMEOUT);
        end
        total++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL timeout release: oe=%b want 00", {ps2_clk_oe, ps2_data_oe});
        end
        repeat (3) @(negedge clk);
        total++;
        if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0 || tx_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timeout pulses: err=%0d done=%0d ready=%b want 1 0 1",
                     err_cnt - e0, done_cnt - d0, tx_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits;
        logic       sb;
        bit         ok;
        int         n, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        tx_data = 8'hF4;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h55;
        device_xfer(1'b1, 0, sb, bits, ok);
        total++;
        if (!ok || bits !== model_frame(8'hF4)) begin
            bad++;
            $display("[TB] FAIL b2b first: got %b want %b", bits, model_frame(8'hF4));
        end
        n = 0;
        while (!(busy === 1'b1 && ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        total++;
        if (n >= 400 || (done_cnt - d0) !== 1) begin
            bad++;
            $display("[TB] FAIL b2b accept: waited %0d done=%0d want second accept after 1 done", n, done_cnt - d0);
        end
        device_xfer(1'b1, 0, sb, bits, ok);
        total++;
        if (!ok || bits !== model_frame(8'h55)) begin
            bad++;
            $display("[TB] FAIL b2b second: got %b want %b", bits, model_frame(8'h55));
        end
        n = 0;
        while (done_cnt - d0 < 2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        total++;
        if ((done_cnt - d0) !== 2 || (err_cnt - e0) !== 0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b end: done=%0d err=%0d busy=%b want 2 0 0", done_cnt - d0, err_cnt - e0, busy);
        end
    endtask

    task automatic test_glitch();
        run_transfer(8'h3C, 1'b1, 3, "glitch");
    endtask

    task automatic test_reset_mid_send();
        int n, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        tx_data = 8'h96;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 3 * (INHIBIT + SETUP)) begin
            @(negedge clk);
            n++;
        end
        repeat (30) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({ps2_clk_oe, ps2_data_oe, busy, tx_ready} !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL midreset: clk_oe/data_oe/busy/ready=%b want 0001",
                     {ps2_clk_oe, ps2_data_oe, busy, tx_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({ps2_clk_oe, ps2_data_oe, busy, tx_ready} !== 4'b0001 || done_cnt != d0 || err_cnt != e0) begin
            bad++;
            $display("[TB] FAIL midreset idle: outs=%b done=%0d err=%0d want 0001 0 0",
                     {ps2_clk_oe, ps2_data_oe, busy, tx_ready}, done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            run_transfer(b, 1'b1, 0, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_f4();
        test_parity();
        test_no_ack();
        test_timeout();
        test_back_to_back();
        test_glitch();
        test_reset_mid_send();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
